// File: rtl/id_ex_stage_if.sv
// Bus bundle between decode, the ID/EX register, the forwarding sources and the ALU.
interface id_ex_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          in_valid;
   logic [DW-1:0] in_rs_data;
   logic [DW-1:0] in_rt_data;
   logic [DW-1:0] in_imm;
   logic [RW-1:0] in_rs_addr;
   logic [RW-1:0] in_rt_addr;
   logic [RW-1:0] in_rd_addr;
   logic [3:0]    in_alu_op;
   logic          in_alu_src;
   logic          in_reg_write;
   logic          in_mem_read;
   logic          stall;
   logic          flush;
   logic          exmem_reg_write;
   logic [RW-1:0] exmem_rd;
   logic [DW-1:0] exmem_data;
   logic          memwb_reg_write;
   logic [RW-1:0] memwb_rd;
   logic [DW-1:0] memwb_data;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [3:0]    alu_op;
   logic          ex_valid;
   logic [RW-1:0] ex_rd_addr;
   logic          ex_reg_write;
   logic          ex_mem_read;
   logic [DW-1:0] ex_store_data;
   logic          load_use_hazard;

   modport master (
      output in_valid, in_rs_data, in_rt_data, in_imm, in_rs_addr, in_rt_addr, in_rd_addr,
             in_alu_op, in_alu_src, in_reg_write, in_mem_read, stall, flush,
             exmem_reg_write, exmem_rd, exmem_data, memwb_reg_write, memwb_rd, memwb_data,
      input  alu_a, alu_b, alu_op, ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read,
             ex_store_data, load_use_hazard
   );

   modport slave (
      input  in_valid, in_rs_data, in_rt_data, in_imm, in_rs_addr, in_rt_addr, in_rd_addr,
             in_alu_op, in_alu_src, in_reg_write, in_mem_read, stall, flush,
             exmem_reg_write, exmem_rd, exmem_data, memwb_reg_write, memwb_rd, memwb_data,
      output alu_a, alu_b, alu_op, ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read,
             ex_store_data, load_use_hazard
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
module id_ex_stage #(
   parameter int          DW     = 32,
   parameter int          RW     = 5,
   parameter logic [3:0]  NOP_OP = 4'b1111
) (
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.slave  bus
);

   logic          valid_q,     valid_d;
   logic [DW-1:0] rs_data_q,   rs_data_d;
   logic [DW-1:0] rt_data_q,   rt_data_d;
   logic [DW-1:0] imm_q,       imm_d;
   logic [RW-1:0] rs_addr_q,   rs_addr_d;
   logic [RW-1:0] rt_addr_q,   rt_addr_d;
   logic [RW-1:0] rd_addr_q,   rd_addr_d;
   logic [3:0]    alu_op_q,    alu_op_d;
   logic          alu_src_q,   alu_src_d;
   logic          reg_write_q, reg_write_d;
   logic          mem_read_q,  mem_read_d;

   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;
   logic          hazard;

   // Operand forwarding: the youngest producer (EX/MEM) wins; register 0 is never forwarded.
   always_comb begin
      fwd_rs = rs_data_q;
      if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs_addr_q)
         fwd_rs = bus.exmem_data;
      else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs_addr_q)
         fwd_rs = bus.memwb_data;

      fwd_rt = rt_data_q;
      if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rt_addr_q)
         fwd_rt = bus.exmem_data;
      else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rt_addr_q)
         fwd_rt = bus.memwb_data;
   end

   // Load-use detection against the instruction currently waiting in ID.
   always_comb begin
      hazard = valid_q && mem_read_q && rd_addr_q != '0 && bus.in_valid &&
               (rd_addr_q == bus.in_rs_addr || rd_addr_q == bus.in_rt_addr);
   end

   // Next-state selection: flush > stall > load-use bubble > normal load.
   always_comb begin
      valid_d     = valid_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      imm_d       = imm_q;
      rs_addr_d   = rs_addr_q;
      rt_addr_d   = rt_addr_q;
      rd_addr_d   = rd_addr_q;
      alu_op_d    = alu_op_q;
      alu_src_d   = alu_src_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      if (bus.flush || (!bus.stall && hazard)) begin
         valid_d     = 1'b0;
         rs_data_d   = '0;
         rt_data_d   = '0;
         imm_d       = '0;
         rs_addr_d   = '0;
         rt_addr_d   = '0;
         rd_addr_d   = '0;
         alu_op_d    = NOP_OP;
         alu_src_d   = 1'b0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
      end else if (bus.stall) begin
         // Capture forwarded operands so they survive the producer retiring during the freeze.
         rs_data_d = fwd_rs;
         rt_data_d = fwd_rt;
      end else begin
         valid_d     = bus.in_valid;
         rs_data_d   = bus.in_rs_data;
         rt_data_d   = bus.in_rt_data;
         imm_d       = bus.in_imm;
         rs_addr_d   = bus.in_rs_addr;
         rt_addr_d   = bus.in_rt_addr;
         rd_addr_d   = bus.in_rd_addr;
         alu_op_d    = bus.in_alu_op;
         alu_src_d   = bus.in_alu_src;
         reg_write_d = bus.in_reg_write;
         mem_read_d  = bus.in_mem_read;
      end
   end

   // Pipeline register; reset presents a NOP bubble to the ALU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rd_addr_q   <= '0;
         alu_op_q    <= NOP_OP;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         rs_addr_q   <= rs_addr_d;
         rt_addr_q   <= rt_addr_d;
         rd_addr_q   <= rd_addr_d;
         alu_op_q    <= alu_op_d;
         alu_src_q   <= alu_src_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
      end
   end

   // Output drive; write/read strobes are masked whenever EX is empty.
   always_comb begin
      bus.alu_a           = fwd_rs;
      bus.alu_b           = alu_src_q ? imm_q : fwd_rt;
      bus.ex_store_data   = fwd_rt;
      bus.alu_op          = alu_op_q;
      bus.ex_valid        = valid_q;
      bus.ex_rd_addr      = rd_addr_q;
      bus.ex_reg_write    = valid_q && reg_write_q;
      bus.ex_mem_read     = valid_q && mem_read_q;
      bus.load_use_hazard = hazard;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   id_ex_stage_if #(.DW(DW), .RW(RW)) bus ();

   id_ex_stage #(.DW(DW), .RW(RW), .NOP_OP(4'b1111)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and let outputs settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.in_valid = 0; bus.in_rs_data = 0; bus.in_rt_data = 0; bus.in_imm = 0;
      bus.in_rs_addr = 0; bus.in_rt_addr = 0; bus.in_rd_addr = 0; bus.in_alu_op = 0;
      bus.in_alu_src = 0; bus.in_reg_write = 0; bus.in_mem_read = 0;
      bus.stall = 0; bus.flush = 0;
      bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_data = 0;
      bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
   endtask

   task automatic drive_instr(input logic [4:0] rs, input logic [31:0] rs_d,
                              input logic [4:0] rt, input logic [31:0] rt_d,
                              input logic [4:0] rd, input logic [3:0] op,
                              input logic src, input logic [31:0] imm,
                              input logic rw, input logic mr);
      bus.in_valid = 1; bus.in_rs_addr = rs; bus.in_rs_data = rs_d;
      bus.in_rt_addr = rt; bus.in_rt_data = rt_d; bus.in_rd_addr = rd;
      bus.in_alu_op = op; bus.in_alu_src = src; bus.in_imm = imm;
      bus.in_reg_write = rw; bus.in_mem_read = mr;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clear_inputs();
      rst_n = 0;
      #12 rst_n = 1;
      #1;
      chk("reset_alu_op", {28'd0, bus.alu_op}, 32'hF);
      chk("reset_valid", {31'd0, bus.ex_valid}, 32'd0);

      // Reset asserted mid-cycle takes effect without a clock edge.
      drive_instr(5'd1, 32'h55, 5'd2, 32'h66, 5'd3, 4'd2, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      chk("pre_rst_alu_a", bus.alu_a, 32'h55);
      chk("pre_rst_op", {28'd0, bus.alu_op}, 32'h2);
      #2 rst_n = 0;
      #1;
      chk("async_rst_op", {28'd0, bus.alu_op}, 32'hF);
      chk("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("async_rst_alu_a", bus.alu_a, 32'd0);
      chk("async_rst_alu_b", bus.alu_b, 32'd0);
      chk("async_rst_rw", {31'd0, bus.ex_reg_write}, 32'd0);
      #1 rst_n = 1;

      // EX/MEM beats MEM/WB, then MEM/WB alone, then registered value.
      drive_instr(5'd3, 32'h5, 5'd2, 32'h7, 5'd9, 4'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_data = 32'h10;
      bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_data = 32'h20;
      #1;
      chk("fwd_exmem_wins", bus.alu_a, 32'h10);
      chk("fwd_rt_none", bus.alu_b, 32'h7);
      chk("store_rt_none", bus.ex_store_data, 32'h7);
      chk("ex_rd_addr", {27'd0, bus.ex_rd_addr}, 32'd9);
      bus.exmem_reg_write = 0;
      #1;
      chk("fwd_memwb", bus.alu_a, 32'h20);
      bus.memwb_reg_write = 0;
      #1;
      chk("fwd_none", bus.alu_a, 32'h5);

      // Immediate source for alu_b; store data still forwarded rt.
      drive_instr(5'd1, 32'h1, 5'd3, 32'h2, 5'd4, 4'd1, 1'b1, 32'h99, 1'b0, 1'b0);
      step();
      bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_data = 32'h33;
      #1;
      chk("alu_b_imm", bus.alu_b, 32'h99);
      chk("store_fwd_rt", bus.ex_store_data, 32'h33);
      chk("rw_gated_off", {31'd0, bus.ex_reg_write}, 32'd0);

      // Register 0 is never forwarded.
      clear_inputs();
      drive_instr(5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 4'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_data = 32'hFF;
      bus.memwb_reg_write = 1; bus.memwb_rd = 0; bus.memwb_data = 32'hEE;
      #1;
      chk("zero_reg_a", bus.alu_a, 32'h0);
      chk("zero_reg_b", bus.alu_b, 32'h0);

      // Load-use: lw $8 in EX, consumer of $8 in ID.
      clear_inputs();
      drive_instr(5'd1, 32'h100, 5'd0, 32'h0, 5'd8, 4'd0, 1'b1, 32'h4, 1'b1, 1'b1);
      step();
      drive_instr(5'd8, 32'h0, 5'd9, 32'h3, 5'd10, 4'd3, 1'b0, 32'd0, 1'b1, 1'b0);
      #1;
      chk("lu_hazard", {31'd0, bus.load_use_hazard}, 32'd1);
      chk("lu_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
      step();
      chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("lu_bubble_op", {28'd0, bus.alu_op}, 32'hF);
      chk("lu_hazard_clear", {31'd0, bus.load_use_hazard}, 32'd0);
      step();
      bus.memwb_reg_write = 1; bus.memwb_rd = 8; bus.memwb_data = 32'hABCD;
      #1;
      chk("lu_consumer_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("lu_consumer_op", {28'd0, bus.alu_op}, 32'h3);
      chk("lu_memwb_fwd", bus.alu_a, 32'hABCD);

      // Load to $0 never raises a hazard.
      clear_inputs();
      drive_instr(5'd1, 32'h0, 5'd0, 32'h0, 5'd0, 4'd0, 1'b1, 32'h0, 1'b1, 1'b1);
      step();
      drive_instr(5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 4'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      #1;
      chk("lu_r0_none", {31'd0, bus.load_use_hazard}, 32'd0);

      // Stall holds a MEM/WB-forwarded operand after the producer retires.
      clear_inputs();
      bus.memwb_reg_write = 1; bus.memwb_rd = 4; bus.memwb_data = 32'h77;
      drive_instr(5'd4, 32'h1, 5'd0, 32'h0, 5'd6, 4'd5, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      chk("stall_pre_fwd", bus.alu_a, 32'h77);
      bus.stall = 1;
      drive_instr(5'd1, 32'h2, 5'd1, 32'h2, 5'd7, 4'd7, 1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         bus.memwb_rd = 5'd9; bus.memwb_data = 32'h88 + i;
         #1;
         chk($sformatf("stall_hold_a_%0d", i), bus.alu_a, 32'h77);
         chk($sformatf("stall_hold_op_%0d", i), {28'd0, bus.alu_op}, 32'h5);
      end
      chk("stall_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("stall_rw", {31'd0, bus.ex_reg_write}, 32'd1);

      // Flush wins over stall.
      bus.memwb_reg_write = 0;
      bus.flush = 1;
      step();
      chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("flush_rw", {31'd0, bus.ex_reg_write}, 32'd0);
      chk("flush_op", {28'd0, bus.alu_op}, 32'hF);
      chk("flush_alu_a", bus.alu_a, 32'd0);
      bus.flush = 0;
      bus.stall = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
